speck_decrypt_control: RTL and testbench

//  Inverse of the three-round SPECK-128/128 encrypt controller: takes a ciphertext and 128-bit key and recovers the plaintext.

---
 rtl/speck_pkg.sv | 20 ++
 rtl/speck_round_decrypt.sv | 17 +
 rtl/speck_decrypt_control.sv | 168 ++++++++++++++++
 tb/tb_speck_decrypt_control.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/speck_pkg.sv
// Shared SPECK-128/128 constants, rotate helpers and controller state encoding.
package speck_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned ALPHA  = 8;
  localparam int unsigned BETA   = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYGEN = 2'd1;
  localparam logic [1:0] ROUNDS = 2'd2;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned amt);
    return (v >> amt) | (v << (WORD_W - amt));
  endfunction

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned amt);
    return (v << amt) | (v >> (WORD_W - amt));
  endfunction

endpackage

// File: rtl/speck_round_decrypt.sv
// Combinational SPECK inverse round: undoes one encrypt round given its round key.
module speck_round_decrypt
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] k,
  output logic [WORD_W-1:0] x_next_c,
  output logic [WORD_W-1:0] y_next_c
);

  always_comb begin
    y_next_c = ror(y ^ x, BETA);
    x_next_c = rol((x ^ k) - y_next_c, ALPHA);
  end

endmodule

// File: rtl/speck_decrypt_control.sv
// SPECK-128/128 decrypt controller: forward key expansion, then reverse-order inverse rounds.
// Optional key cache skipping KEYGEN for a repeated key: define SPECK_DEC_KEY_CACHE_EN.
module speck_decrypt_control
  import speck_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*WORD_W-1:0] key,
  input  logic [2*WORD_W-1:0] ciphertext,
  output logic [2*WORD_W-1:0] plaintext,
  output logic                finished,
  output logic                busy,
  output logic [4:0]          state_response
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);
  localparam logic [4:0] GEN_LAST = 5'((NUM_ROUNDS >= 2) ? (NUM_ROUNDS - 2) : 0);

  logic [1:0]          state_q, state_d;
  logic [4:0]          counter_q, counter_d;
  logic [WORD_W-1:0]   x_q, x_d, y_q, y_d, l_q, l_d, k_q, k_d;
  logic [2*WORD_W-1:0] pt_d;
  logic                fin_d, busy_d;
  logic [WORD_W-1:0]   rk [NUM_ROUNDS];
  logic                rk_we;
  logic [4:0]          rk_idx;
  logic [WORD_W-1:0]   rk_wdata, rk_sel;
  logic [WORD_W-1:0]   l_next, k_next, x_next_c, y_next_c;
  logic                cache_hit_c;

  // One key-schedule step from the current (l, k_i) pair
  assign l_next = (ror(l_q, ALPHA) + k_q) ^ WORD_W'(counter_q);
  assign k_next = rol(k_q, BETA) ^ l_next;

  always_comb begin
    rk_sel = '0;
    for (int j = 0; j < int'(NUM_ROUNDS); j++)
      if (counter_q == 5'(j)) rk_sel = rk[j];
  end

  speck_round_decrypt u_round (
    .x        (x_q),
    .y        (y_q),
    .k        (rk_sel),
    .x_next_c (x_next_c),
    .y_next_c (y_next_c)
  );

`ifdef SPECK_DEC_KEY_CACHE_EN
  logic [2*WORD_W-1:0] cache_key_q;
  logic                cache_valid_q;

  assign cache_hit_c = cache_valid_q && (key == cache_key_q);

  // Cache only becomes valid once the whole schedule for cache_key_q is in rk
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
    end else if (state_q == IDLE && start && !cache_hit_c) begin
      cache_key_q   <= key;
      cache_valid_q <= 1'b0;
    end else if (state_q == KEYGEN && counter_q == GEN_LAST) begin
      cache_valid_q <= 1'b1;
    end
  end
`else
  assign cache_hit_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    x_d       = x_q;
    y_d       = y_q;
    l_d       = l_q;
    k_d       = k_q;
    pt_d      = plaintext;
    fin_d     = 1'b0;
    rk_we     = 1'b0;
    rk_idx    = counter_q;
    rk_wdata  = k_next;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = ciphertext[2*WORD_W-1:WORD_W];
          y_d       = ciphertext[WORD_W-1:0];
          l_d       = key[2*WORD_W-1:WORD_W];
          k_d       = key[WORD_W-1:0];
          rk_we     = 1'b1;
          rk_idx    = 5'd0;
          rk_wdata  = key[WORD_W-1:0];
          counter_d = 5'd0;
          if (NUM_ROUNDS == 1 || cache_hit_c) begin
            state_d   = ROUNDS;
            counter_d = LAST_IDX;
          end else begin
            state_d = KEYGEN;
          end
        end
      end
      KEYGEN: begin
        rk_we    = 1'b1;
        rk_idx   = 5'(counter_q + 5'd1);
        rk_wdata = k_next;
        l_d      = l_next;
        k_d      = k_next;
        if (counter_q == GEN_LAST) begin
          counter_d = LAST_IDX;
          state_d   = ROUNDS;
        end else begin
          counter_d = 5'(counter_q + 5'd1);
        end
      end
      ROUNDS: begin
        x_d = x_next_c;
        y_d = y_next_c;
        if (counter_q == 5'd0) begin
          pt_d    = {x_next_c, y_next_c};
          fin_d   = 1'b1;
          state_d = IDLE;
        end else begin
          counter_d = 5'(counter_q - 5'd1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == KEYGEN) || (state_d == ROUNDS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      l_q       <= '0;
      k_q       <= '0;
      plaintext <= '0;
      finished  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      x_q       <= x_d;
      y_q       <= y_d;
      l_q       <= l_d;
      k_q       <= k_d;
      plaintext <= pt_d;
      finished  <= fin_d;
      busy      <= busy_d;
    end
  end

  // Round-key store needs no reset: every entry is written before it is read
  always_ff @(posedge clk) begin
    if (rk_we) begin
      for (int j = 0; j < int'(NUM_ROUNDS); j++)
        if (rk_idx == 5'(j)) rk[j] <= rk_wdata;
    end
  end

  assign state_response = counter_q;

endmodule

// File: tb/tb_speck_decrypt_control.sv
// Directed bench for speck_decrypt_control at NUM_ROUNDS = 3, 32 and 1.
// Latency expectations follow SPECK_DEC_KEY_CACHE_EN when it is defined.
module tb_speck_decrypt_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start3 = 1'b0, start32 = 1'b0, start1 = 1'b0;
  logic [127:0] key3 = '0, key32 = '0, key1 = '0;
  logic [127:0] ct3 = '0, ct32 = '0, ct1 = '0;
  logic [127:0] pt3, pt32, pt1;
  logic         fin3, fin32, fin1, busy3, busy32, busy1;
  logic [4:0]   sr3, sr32, sr1;

  int n_cmp = 0;
  int n_err = 0;

  speck_decrypt_control #(.NUM_ROUNDS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .key(key3), .ciphertext(ct3),
    .plaintext(pt3), .finished(fin3), .busy(busy3), .state_response(sr3));
  speck_decrypt_control #(.NUM_ROUNDS(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .key(key32), .ciphertext(ct32),
    .plaintext(pt32), .finished(fin32), .busy(busy32), .state_response(sr32));
  speck_decrypt_control #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key(key1), .ciphertext(ct1),
    .plaintext(pt1), .finished(fin1), .busy(busy1), .state_response(sr1));

  function automatic logic [63:0] ror64(input logic [63:0] v, input int a);
    logic [127:0] t;
    t = {v, v} >> a;
    return t[63:0];
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int a);
    logic [127:0] t;
    t = {v, v} << a;
    return t[127:64];
  endfunction

  // Forward (encrypt) reference: the DUT must invert this
  function automatic logic [127:0] speck_enc(input logic [127:0] k128, input logic [127:0] p, input int n);
    logic [63:0] l, k, x, y;
    l = k128[127:64]; k = k128[63:0]; x = p[127:64]; y = p[63:0];
    for (int i = 0; i < n; i++) begin
      x = (ror64(x, 8) + y) ^ k;
      y = rol64(y, 3) ^ x;
      if (i < n - 1) begin
        l = (ror64(l, 8) + k) ^ 64'(i);
        k = rol64(k, 3) ^ l;
      end
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic s, input logic [127:0] k, input logic [127:0] c);
    case (sel)
      3:  begin start3 = s;  key3 = k;  ct3 = c;  end
      32: begin start32 = s; key32 = k; ct32 = c; end
      default: begin start1 = s; key1 = k; ct1 = c; end
    endcase
  endtask

  function automatic logic cur_fin(input int sel);
    return (sel == 3) ? fin3 : (sel == 32) ? fin32 : fin1;
  endfunction
  function automatic logic cur_busy(input int sel);
    return (sel == 3) ? busy3 : (sel == 32) ? busy32 : busy1;
  endfunction
  function automatic logic [127:0] cur_pt(input int sel);
    return (sel == 3) ? pt3 : (sel == 32) ? pt32 : pt1;
  endfunction

  // Single operation; inputs are scrambled right after capture
  task automatic run_op(input int sel, input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] exp_pt, input int exp_lat, input string tag);
    int lat, busy_n;
    bit done;
    @(negedge clk);
    set_in(sel, 1'b1, k, c);
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~k, ~c);
    busy_n = cur_busy(sel) ? 1 : 0;
    lat = 0; done = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (cur_fin(sel)) done = 1;
      else if (cur_busy(sel)) busy_n++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_pt"}, cur_pt(sel), exp_pt);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_fin_single"}, 128'(cur_fin(sel)), 128'(0));
  endtask

  task automatic check_reset3(input string tag);
    check({tag, "_pt"}, pt3, 128'(0));
    check({tag, "_fin"}, 128'(fin3), 128'(0));
    check({tag, "_busy"}, 128'(busy3), 128'(0));
    check({tag, "_sr"}, 128'(sr3), 128'(0));
  endtask

  initial begin
    logic [127:0] k, p, c, ka, kb, pa, pb, ca, cb, fp1, fp2;
    int hit_lat, pulses, fc1, fc2;
`ifdef SPECK_DEC_KEY_CACHE_EN
    hit_lat = 3;
`else
    hit_lat = 5;
`endif

    // Reset values on all instances
    repeat (2) @(posedge clk);
    #1;
    check_reset3("rst_dut3");
    check("rst_dut32_pt", pt32, 128'(0));
    check("rst_dut32_out", {fin32, busy32, sr32}, 128'(0));
    check("rst_dut1_pt", pt1, 128'(0));
    check("rst_dut1_out", {fin1, busy1, sr1}, 128'(0));
    rst = 1'b0;

    // Published 32-round test vector
    run_op(32, 128'h0f0e0d0c0b0a0908_0706050403020100, 128'ha65d985179783265_7860fedf5c570d18,
           128'h6c61766975716520_7469206564616d20, 63, "kat32");

    // Random key/plaintext pairs, three rounds
    for (int i = 0; i < 200; i++) begin
      k = rnd128(); p = rnd128();
      run_op(3, k, speck_enc(k, p, 3), p, 5, "rand3");
    end

    // Back-to-back with start held high and inputs changed mid-operation
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    ka = rnd128(); pa = rnd128(); ca = speck_enc(ka, pa, 3);
    kb = rnd128(); pb = rnd128(); cb = speck_enc(kb, pb, 3);
    @(negedge clk); set_in(3, 1'b1, ka, ca);
    @(posedge clk);
    pulses = 0; fc1 = -1; fc2 = -1; fp1 = '0; fp2 = '0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clk); #1;
      if (fin3) begin
        pulses++;
        if (pulses == 1) begin fc1 = cyc; fp1 = pt3; end
        else begin fc2 = cyc; fp2 = pt3; end
      end
      if (cyc == 2) set_in(3, 1'b1, kb, cb);
      if (cyc == 6) set_in(3, 1'b0, rnd128(), rnd128());
    end
    check("b2b_pulses", 128'(pulses), 128'(2));
    check("b2b_first_cycle", 128'(fc1), 128'(5));
    check("b2b_first_pt", fp1, pa);
    check("b2b_second_cycle", 128'(fc2), 128'(11));
    check("b2b_second_pt", fp2, pb);

    // Reset mid-KEYGEN
    k = rnd128(); p = rnd128();
    @(negedge clk); set_in(3, 1'b1, k, speck_enc(k, p, 3));
    @(posedge clk); #1;
    set_in(3, 1'b0, k, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset3("rst_keygen");
    k = rnd128(); p = rnd128();
    run_op(3, k, speck_enc(k, p, 3), p, 5, "after_rst_keygen");

    // Reset mid-ROUNDS
    k = rnd128(); p = rnd128();
    @(negedge clk); set_in(3, 1'b1, k, speck_enc(k, p, 3));
    @(posedge clk); #1;
    set_in(3, 1'b0, k, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset3("rst_rounds");
    k = rnd128(); p = rnd128();
    run_op(3, k, speck_enc(k, p, 3), p, 5, "after_rst_rounds");

    // Key reuse (skips KEYGEN only when the cache is built)
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    k = rnd128(); p = rnd128();
    run_op(3, k, speck_enc(k, p, 3), p, 5, "cache_first");
    p = rnd128();
    run_op(3, k, speck_enc(k, p, 3), p, hit_lat, "cache_same");
    ka = rnd128(); p = rnd128();
    run_op(3, ka, speck_enc(ka, p, 3), p, 5, "cache_newkey");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    p = rnd128();
    run_op(3, ka, speck_enc(ka, p, 3), p, 5, "cache_after_rst");

    // Single-round instance
    for (int i = 0; i < 4; i++) begin
      k = rnd128(); p = rnd128();
      run_op(1, k, speck_enc(k, p, 1), p, 1, "n1");
    end
    c = 128'h0123456789abcdef_fedcba9876543210;
    k = 128'h0;
    run_op(1, k, c, {rol64((c[127:64] ^ 64'h0) - ror64(c[63:0] ^ c[127:64], 3), 8),
                     ror64(c[63:0] ^ c[127:64], 3)}, 1, "n1_zero_key");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
